// File: rtl/ram_pattern_filler.sv
// Fill engine for port B of a dual-port RAM: writes an INC/CONST/ADDR/LFSR pattern to 0..DEPTH-1.
// Define RAM_FILL_VERIFY_EN to build the readback pass that counts mismatches on q_b.
module ram_pattern_filler #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 4096,
  parameter     LFSR_POLY = 16'hB400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_b,
  output logic              we_b,
  input  logic [DATA_W-1:0] q_b,
  output logic              err,
  output logic [ADDR_W:0]   err_count
);

  typedef enum logic [1:0] {IDLE, FILL, VERIFY, DONE} state_t;

  localparam logic [1:0]        MODE_INC  = 2'd0;
  localparam logic [1:0]        MODE_CONST = 2'd1;
  localparam logic [1:0]        MODE_ADDR = 2'd2;
  localparam logic [DATA_W-1:0] POLY      = DATA_W'(LFSR_POLY);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  state_t            state_reg, state_next;
  logic [1:0]        mode_reg;
  logic [DATA_W-1:0] seed_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [DATA_W-1:0] gen_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              we_reg;

  logic              start_ok;
  logic              last_idx;
  logic [ADDR_W-1:0] idx_inc;
  logic [DATA_W-1:0] gen_next;

  // Every mode starts at the seed itself; only the LFSR must avoid the all-zero lock-up state.
  function automatic logic [DATA_W-1:0] first_word(input logic [1:0] m, input logic [DATA_W-1:0] s);
    if (m == 2'd3 && s == '0) return DATA_W'(1);
    return s;
  endfunction

  assign start_ok = start && (state_reg == IDLE || state_reg == DONE);
  assign last_idx = (idx_reg == LAST_IDX);
  assign idx_inc  = idx_reg + 1'b1;

  always_comb begin
    gen_next = gen_reg;
    case (mode_reg)
      MODE_INC:   gen_next = gen_reg + 1'b1;
      MODE_CONST: gen_next = gen_reg;
      MODE_ADDR:  gen_next = seed_reg ^ DATA_W'(idx_inc);
      default:    gen_next = (gen_reg >> 1) ^ (gen_reg[0] ? POLY : '0);
    endcase
  end

`ifdef RAM_FILL_VERIFY_EN
  logic              rd_active_reg;
  logic              cmp_valid_reg;
  logic [DATA_W-1:0] exp_reg;
  logic              err_reg;
  logic [ADDR_W:0]   err_cnt_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start) state_next = FILL;
`ifdef RAM_FILL_VERIFY_EN
      FILL:   if (last_idx) state_next = VERIFY;
      VERIFY: if (cmp_valid_reg && !rd_active_reg) state_next = DONE;
`else
      FILL:   if (last_idx) state_next = DONE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg <= '0;
      seed_reg <= '0;
      idx_reg  <= '0;
      gen_reg  <= '0;
      addr_reg <= '0;
      data_reg <= '0;
      we_reg   <= 1'b0;
`ifdef RAM_FILL_VERIFY_EN
      rd_active_reg <= 1'b0;
      cmp_valid_reg <= 1'b0;
      exp_reg       <= '0;
      err_reg       <= 1'b0;
      err_cnt_reg   <= '0;
`endif
    end else begin
      // Port B idles at zero unless a branch below drives it.
      addr_reg <= '0;
      data_reg <= '0;
      we_reg   <= 1'b0;
      if (start_ok) begin
        mode_reg <= mode;
        seed_reg <= seed;
        idx_reg  <= '0;
        gen_reg  <= first_word(mode, seed);
        data_reg <= first_word(mode, seed);
        we_reg   <= 1'b1;
`ifdef RAM_FILL_VERIFY_EN
        rd_active_reg <= 1'b0;
        cmp_valid_reg <= 1'b0;
        err_reg       <= 1'b0;
        err_cnt_reg   <= '0;
`endif
      end else if (state_reg == FILL) begin
        if (!last_idx) begin
          idx_reg  <= idx_inc;
          gen_reg  <= gen_next;
          addr_reg <= idx_inc;
          data_reg <= gen_next;
          we_reg   <= 1'b1;
        end
`ifdef RAM_FILL_VERIFY_EN
        else begin
          idx_reg       <= '0;
          gen_reg       <= first_word(mode_reg, seed_reg);
          rd_active_reg <= 1'b1;
        end
      end else if (state_reg == VERIFY) begin
        // exp_reg trails the issued address by one cycle to line up with q_b.
        if (cmp_valid_reg && q_b != exp_reg) begin
          err_reg <= 1'b1;
          if (~&err_cnt_reg) err_cnt_reg <= err_cnt_reg + 1'b1;
        end
        cmp_valid_reg <= rd_active_reg;
        exp_reg       <= gen_reg;
        if (rd_active_reg) begin
          if (last_idx) begin
            rd_active_reg <= 1'b0;
          end else begin
            idx_reg  <= idx_inc;
            gen_reg  <= gen_next;
            addr_reg <= idx_inc;
          end
        end
`endif
      end
    end
  end

  assign busy   = (state_reg == FILL) || (state_reg == VERIFY);
  assign done   = (state_reg == DONE);
  assign addr_b = addr_reg;
  assign data_b = data_reg;
  assign we_b   = we_reg;

`ifdef RAM_FILL_VERIFY_EN
  assign err       = err_reg;
  assign err_count = err_cnt_reg;
`else
  logic unused_q;
  assign unused_q  = ^q_b;
  assign err       = 1'b0;
  assign err_count = '0;
`endif

endmodule
